// File: rtl/reg_file_host.sv
// Serial command front-end for a small register file: decodes framed
// serial write/read commands and streams read data back out MSB first.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   ser_in         : serial command bit, qualified by ser_valid
//   ser_valid      : ser_in qualifier; a bit is taken only while busy=0
//   busy           : high while the block ignores incoming command bits
//   rf_rd_addr     : register-file read address (registered)
//   rf_rd_data     : register-file read data, one cycle after rf_rd_addr
//   rf_wr_addr     : register-file write address (registered)
//   rf_wr_data     : register-file write data (registered)
//   rf_wr_en       : one-cycle register-file write strobe
//   ser_out        : serial read-back bit, 0 while ser_out_valid=0
//   ser_out_valid  : qualifies ser_out
module reg_file_host #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ser_in,
   input  logic              ser_valid,
   output logic              busy,
   output logic [ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              rf_wr_en,
   output logic              ser_out,
   output logic              ser_out_valid
);

   localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CW   = $clog2(MAXW) + 1;

   localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
   localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_WRITE,
      S_RD_ADDR,
      S_RD_WAIT,
      S_SHIFT
   } state_t;

   state_t state;
   state_t state_nxt;

   logic              op;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] addr_sr;
   logic [DATA_W-1:0] data_sr;
   logic [DATA_W-1:0] out_sr;

   logic              accept;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] data_nxt;

   assign accept   = ser_valid & ~busy;
   assign addr_nxt = (addr_sr << 1) | ADDR_W'(ser_in);
   assign data_nxt = (data_sr << 1) | DATA_W'(ser_in);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (accept) state_nxt = S_ADDR;
         end
         S_ADDR: begin
            if (accept && cnt == A_LAST)
               state_nxt = op ? S_DATA : S_RD_ADDR;
         end
         S_DATA: begin
            if (accept && cnt == D_LAST)
               state_nxt = S_WRITE;
         end
         S_WRITE:   state_nxt = S_IDLE;
         S_RD_ADDR: state_nxt = S_RD_WAIT;
         S_RD_WAIT: state_nxt = S_SHIFT;
         S_SHIFT: begin
            if (cnt == D_LAST) state_nxt = S_IDLE;
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from the state register only
   always_comb begin
      busy          = 1'b0;
      rf_wr_en      = 1'b0;
      ser_out_valid = 1'b0;
      ser_out       = 1'b0;
      unique case (state)
         S_IDLE, S_ADDR, S_DATA: busy = 1'b0;
         S_WRITE: begin
            busy     = 1'b1;
            rf_wr_en = 1'b1;
         end
         S_RD_ADDR, S_RD_WAIT: busy = 1'b1;
         S_SHIFT: begin
            busy          = 1'b1;
            ser_out_valid = 1'b1;
            ser_out       = out_sr[DATA_W-1];
         end
         default: busy = 1'b0;
      endcase
   end

   // Datapath: bit counter, shift registers, register-file ports
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op         <= 1'b0;
         cnt        <= '0;
         addr_sr    <= '0;
         data_sr    <= '0;
         out_sr     <= '0;
         rf_rd_addr <= '0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  op  <= ser_in;
                  cnt <= '0;
               end
            end
            S_ADDR: begin
               if (accept) begin
                  addr_sr <= addr_nxt;
                  if (cnt == A_LAST) begin
                     cnt <= '0;
                     // read address goes out on the same edge as the last bit
                     if (!op) rf_rd_addr <= addr_nxt;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  data_sr <= data_nxt;
                  if (cnt == D_LAST) begin
                     cnt        <= '0;
                     rf_wr_addr <= addr_sr;
                     rf_wr_data <= data_nxt;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            S_RD_WAIT: begin
               out_sr <= rf_rd_data;
            end
            S_SHIFT: begin
               out_sr <= out_sr << 1;
               if (cnt == D_LAST) cnt <= '0;
               else               cnt <= cnt + CW'(1);
            end
            S_WRITE, S_RD_ADDR: begin
               cnt <= '0;
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_host.sv
// Bench for reg_file_host: directed and random serial frames against a
// frame-level register model and an attached register-file memory.
module tb_reg_file_host;

   localparam int AW = 3;
   localparam int DW = 8;
   localparam int NR = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic          ser_in;
   logic          ser_valid;
   logic          busy;
   logic [AW-1:0] rf_rd_addr;
   logic [DW-1:0] rf_rd_data;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_wr_data;
   logic          rf_wr_en;
   logic          ser_out;
   logic          ser_out_valid;

   int errors = 0;
   int checks = 0;
   int wr_count = 0;
   int exp_wr = 0;

   logic [DW-1:0] seed_vals [NR];
   logic [DW-1:0] ref_mem [NR];
   logic [DW-1:0] rf_mem [NR];
   logic          init_done = 1'b0;

   reg_file_host #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ser_in        (ser_in),
      .ser_valid     (ser_valid),
      .busy          (busy),
      .rf_rd_addr    (rf_rd_addr),
      .rf_rd_data    (rf_rd_data),
      .rf_wr_addr    (rf_wr_addr),
      .rf_wr_data    (rf_wr_data),
      .rf_wr_en      (rf_wr_en),
      .ser_out       (ser_out),
      .ser_out_valid (ser_out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attached register file: synchronous read, one-cycle latency
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < NR; i++) rf_mem[i] = seed_vals[i];
         init_done = 1'b1;
      end
      if (rf_wr_en) rf_mem[rf_wr_addr] = rf_wr_data;
      rf_rd_data <= rf_mem[rf_rd_addr];
      if (rf_wr_en) wr_count = wr_count + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one bit after 'gap' idle cycles; returns right after the
   // edge that accepted it.
   task automatic send_bit(input logic b, input int gap);
      for (int i = 0; i < gap; i++) begin
         ser_valid = 1'b0;
         @(posedge clk); #1;
      end
      ser_valid = 1'b1;
      ser_in    = b;
      @(negedge clk);
      chk("busy_before_accept", busy, 0);
      @(posedge clk); #1;
      ser_valid = 1'b0;
      ser_in    = 1'b0;
   endtask

   function automatic int pick_gap(input int mn, input int mx);
      return (mx == 0) ? 0 : int'($urandom_range(mx, mn));
   endfunction

   task automatic send_hdr(input logic op, input logic [AW-1:0] a,
                           input int mn, input int mx);
      send_bit(op, pick_gap(mn, mx));
      for (int i = AW - 1; i >= 0; i--) send_bit(a[i], pick_gap(mn, mx));
   endtask

   task automatic wr_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int mn, input int mx, input bit hold);
      send_hdr(1'b1, a, mn, mx);
      for (int i = DW - 1; i >= 0; i--) send_bit(d[i], pick_gap(mn, mx));
      if (hold) begin
         ser_valid = 1'b1;
         ser_in    = 1'($urandom);
      end
      @(negedge clk);
      chk("wr_en_pulse", rf_wr_en, 1);
      chk("wr_addr", rf_wr_addr, a);
      chk("wr_data", rf_wr_data, d);
      chk("busy_write", busy, 1);
      @(posedge clk); #1;
      ser_valid = 1'b0;
      @(negedge clk);
      chk("wr_en_after", rf_wr_en, 0);
      chk("busy_after_write", busy, 0);
      chk("wr_data_hold", rf_wr_data, d);
      @(posedge clk); #1;
      ref_mem[a] = d;
      exp_wr++;
   endtask

   task automatic rd_frame(input logic [AW-1:0] a,
                           input int mn, input int mx, input bit hold);
      logic [DW-1:0] exp;
      exp = ref_mem[a];
      send_hdr(1'b0, a, mn, mx);
      // cycles N+1 .. N+2+DW after the last address bit
      for (int k = 1; k <= DW + 2; k++) begin
         if (hold) begin
            ser_valid = 1'b1;
            ser_in    = 1'($urandom);
         end
         @(negedge clk);
         chk("busy_read", busy, 1);
         if (k == 1) chk("rd_addr", rf_rd_addr, a);
         if (k <= 2) begin
            chk("out_valid_early", ser_out_valid, 0);
            chk("out_zero_early", ser_out, 0);
         end else begin
            chk("out_valid", ser_out_valid, 1);
            chk("ser_out_bit", ser_out, exp[DW - 1 - (k - 3)]);
         end
         @(posedge clk); #1;
      end
      ser_valid = 1'b0;
      @(negedge clk);
      chk("out_valid_end", ser_out_valid, 0);
      chk("busy_after_read", busy, 0);
      chk("rd_addr_hold", rf_rd_addr, a);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_busy", busy, 0);
      chk("rst_wr_en", rf_wr_en, 0);
      chk("rst_wr_addr", rf_wr_addr, 0);
      chk("rst_wr_data", rf_wr_data, 0);
      chk("rst_rd_addr", rf_rd_addr, 0);
      chk("rst_ser_out", ser_out, 0);
      chk("rst_out_valid", ser_out_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      int snap;

      rst_n     = 1'b0;
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      for (int i = 0; i < NR; i++) seed_vals[i] = DW'($urandom);
      seed_vals[5] = 8'h3C;
      for (int i = 0; i < NR; i++) ref_mem[i] = seed_vals[i];

      #3;
      chk_reset_outputs();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      rd_frame(3'd5, 0, 0, 1'b0);
      wr_frame(3'd5, 8'hA5, 0, 0, 1'b0);
      wr_frame(3'd5, 8'hA5, 1, 3, 1'b0);
      rd_frame(3'd5, 1, 3, 1'b1);
      wr_frame(3'd0, 8'h5A, 0, 0, 1'b1);
      rd_frame(3'd0, 0, 0, 1'b0);
      rd_frame(3'd6, 0, 2, 1'b1);

      // reset after 6 data bits of a write frame
      send_hdr(1'b1, 3'd4, 0, 0);
      for (int i = 0; i < 6; i++) send_bit(1'b1, 0);
      snap = wr_count;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("no_partial_write", wr_count, snap);
      wr_frame(3'd2, 8'h7E, 0, 0, 1'b0);
      rd_frame(3'd2, 0, 0, 1'b0);

      // reset while shifting read data out
      send_hdr(1'b0, 3'd3, 0, 0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_shift_valid", ser_out_valid, 0);
      chk("rst_shift_busy", busy, 0);
      chk("rst_shift_rd_addr", rf_rd_addr, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("no_valid_after_rst", ser_out_valid, 0);
         @(posedge clk); #1;
      end

      for (int n = 0; n < 40; n++) begin
         ra = AW'($urandom);
         rd = DW'($urandom);
         if ($urandom_range(1, 0) == 1)
            wr_frame(ra, rd, 0, int'($urandom_range(3, 0)),
                     1'($urandom));
         else
            rd_frame(ra, 0, int'($urandom_range(3, 0)), 1'($urandom));
      end

      chk("write_count", wr_count, exp_wr);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file_host.md
REG_FILE_HOST -- requirements
Module: reg_file_host

Interface
REQ-001 Parameter ADDR_W, default 3: register address width.
REQ-002 Parameter DATA_W, default 8: register data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ser_in  input  1  serial command bit.
REQ-006 ser_valid  input  1  qualifies ser_in for one cycle.
REQ-007 busy  output  1  high when the block is not accepting command bits.
REQ-008 rf_rd_addr  output  ADDR_W  register-file read address, registered.
REQ-009 rf_rd_data  input  DATA_W  register-file read data, valid one cycle after rf_rd_addr is sampled.
REQ-010 rf_wr_addr  output  ADDR_W  register-file write address, registered.
REQ-011 rf_wr_data  output  DATA_W  register-file write data, registered.
REQ-012 rf_wr_en  output  1  register-file write strobe, registered.
REQ-013 ser_out  output  1  serial read-back bit.
REQ-014 ser_out_valid  output  1  qualifies ser_out.

Function
REQ-015 Frame format, MSB first: op bit (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits for write frames only.
REQ-016 A bit is accepted only on a clock where ser_valid=1 and busy=0; bits with ser_valid=1 and busy=1 are discarded without effect.
REQ-017 States: IDLE, ADDR, DATA, WRITE, RD_ADDR, RD_WAIT, SHIFT; busy=0 in IDLE/ADDR/DATA, busy=1 in WRITE/RD_ADDR/RD_WAIT/SHIFT.
REQ-018 IDLE: accepted bit latched as op -> ADDR.
REQ-019 ADDR: shifts in ADDR_W bits; on the last bit, write op -> DATA; read op -> RD_ADDR with rf_rd_addr loaded on that same edge.
REQ-020 DATA: shifts in DATA_W bits; on the last bit, rf_wr_addr/rf_wr_data loaded on that edge -> WRITE.
REQ-021 WRITE: rf_wr_en=1 for exactly one cycle -> IDLE; rf_wr_addr/rf_wr_data hold their values until the next write frame.
REQ-022 RD_ADDR: one cycle (register file samples rf_rd_addr) -> RD_WAIT.
REQ-023 RD_WAIT: one cycle; rf_rd_data captured into the shift register at the end of the cycle -> SHIFT.
REQ-024 SHIFT: ser_out_valid=1 for exactly DATA_W consecutive cycles, ser_out = captured data MSB first -> IDLE; ser_out=0 whenever ser_out_valid=0.
REQ-025 Write latency: last data bit accepted at edge N -> rf_wr_en high during cycle N+1.
REQ-026 Read latency: last address bit accepted at edge N -> first ser_out bit in cycle N+3, last bit in cycle N+2+DATA_W.
REQ-027 Cycles with ser_valid=0 mid-frame stall the frame indefinitely; there is no timeout.
REQ-028 rf_rd_addr holds its value until the next read frame.
REQ-029 IDLE is re-entered after WRITE or SHIFT with all bit counters cleared; the next frame is accepted starting in the cycle after.

Reset
REQ-030 rst_n=0 immediately forces state IDLE and clears counters and shift registers; busy, rf_wr_en, rf_wr_addr, rf_wr_data, rf_rd_addr, ser_out and ser_out_valid all become 0.
REQ-031 Reset asserted mid-frame or mid-SHIFT abandons the operation; no partial write is issued and no further ser_out_valid pulses occur.
REQ-032 After rst_n returns high, the first accepted bit is treated as an op bit.

Verification
REQ-033 Write frame 1,101,10100101 with contiguous ser_valid -> one cycle of rf_wr_en=1 with rf_wr_addr=5 and rf_wr_data=0xA5; busy=1 in that cycle only.
REQ-034 Read frame 0,101 with a register-file model returning 0x3C for address 5 -> rf_rd_addr=5; ser_out sequence 0,0,1,1,1,1,0,0 on 8 consecutive ser_out_valid cycles starting 3 cycles after the last address bit.
REQ-035 REQ-033 frame with 1-3 idle cycles between bits -> identical write, with timing relative to the last bit unchanged.
REQ-036 ser_valid=1 held throughout RD_ADDR/RD_WAIT/SHIFT -> those bits are ignored; the next frame after IDLE decodes correctly.
REQ-037 rst_n pulsed low after 6 data bits of a write frame -> all outputs 0 and no rf_wr_en; a following complete write frame to address 2 with data 0x7E writes correctly.
REQ-038 Write 0x5A to address 0, then read address 0 with the register-file model -> ser_out returns 0x5A.
